// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window filter: pixel/gradient widths,
// the 3x3 window type and small arithmetic helpers.
package sobel_pkg;

  localparam int DW = 10;
  localparam int GW = 13;
  localparam logic [DW-1:0] PIX_MAX = '1;

  typedef logic [DW-1:0] pix_t;
  // [row][col]: row 0 is the oldest line (top tap), col 2 is the newest pixel.
  typedef logic [2:0][2:0][DW-1:0] win3x3_t;
  typedef logic signed [GW-1:0] grad_t;

  function automatic grad_t px2g(input pix_t p);
    return $signed({{(GW-DW){1'b0}}, p});
  endfunction

  function automatic logic [GW-1:0] abs_g(input grad_t g);
    logic [GW-1:0] u;
    u = g[GW-1] ? -g : g;
    return u;
  endfunction

endpackage

// File: rtl/sobel_window_3x3.sv
// Stage 1 of the Sobel filter: 3x3 column-shift window with column/line
// counters and the border flag for the pixel just captured.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int unsigned MAXW = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vs,
  input  logic          i_val,
  input  logic [DW-1:0] i_top,
  input  logic [DW-1:0] i_mid,
  input  logic [DW-1:0] i_pix,
  output win3x3_t       o_win,
  output logic          o_border
);

  localparam int CW = $clog2(MAXW);

  logic [CW-1:0]        r_col;
  logic [1:0]           r_ln;
  logic                 r_val_d;
  logic                 r_border;
  win3x3_t              r_win;
  logic [2:0][DW-1:0]   w_col;
  logic                 w_line_end;

  assign w_col      = {i_pix, i_mid, i_top};
  assign w_line_end = r_val_d & ~i_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win    <= '0;
      r_border <= 1'b0;
      r_col    <= '0;
      r_ln     <= '0;
      r_val_d  <= 1'b0;
    end else begin
      r_val_d <= i_val;
      if (i_val) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= w_col[r];
        end
        // A pixel arriving with the frame clear sees counters that are about to be zeroed.
        r_border <= (r_col < CW'(2)) || (r_ln < 2'd2) || !i_vs;
      end else if (w_line_end) begin
        r_win <= '0;
      end

      if (!i_vs) begin
        r_col <= '0;
        r_ln  <= '0;
      end else if (i_val) begin
        if (r_col < CW'(2)) r_col <= r_col + CW'(1);
      end else if (w_line_end) begin
        r_col <= '0;
        if (r_ln < 2'd2) r_ln <= r_ln + 2'd1;
      end
    end
  end

  assign o_win    = r_win;
  assign o_border = r_border;

endmodule

// File: rtl/sobel_window_filter.sv
// Sobel |Gx|+|Gy| edge filter, 3-stage pipeline (window, gradients, magnitude).
// Optional SOBEL_THRESH_EN turns the saturated magnitude into a binary edge map.
module sobel_window_filter
  import sobel_pkg::*;
#(
`ifdef SOBEL_THRESH_EN
  parameter int unsigned THRESH = 128,
`endif
  parameter int unsigned MAXW   = 1024
) (
  input  logic          VGA_CLK,
  input  logic          RESET_N,
  input  logic          iVS,
  input  logic          iVAL,
  input  logic [DW-1:0] iTAP_TOP,
  input  logic [DW-1:0] iTAP_MID,
  input  logic [DW-1:0] iPIX,
  output logic          oVAL,
  output logic [DW-1:0] oEDGE
);

  localparam int STAGES = 3;

  win3x3_t          w_win;
  logic             w_border;
  logic             w_unused_center;
  grad_t            w_gx, w_gy;
  logic [GW-1:0]    w_mag;
  logic [DW-1:0]    w_edge;

  logic [STAGES:1]  r_vld_pipe;
  grad_t            r_gx, r_gy;
  logic             r_border2;
  logic [DW-1:0]    r_edge;

  sobel_window_3x3 #(.MAXW(MAXW)) u_win (
    .i_clk    (VGA_CLK),
    .i_rst_n  (RESET_N),
    .i_vs     (iVS),
    .i_val    (iVAL),
    .i_top    (iTAP_TOP),
    .i_mid    (iTAP_MID),
    .i_pix    (iPIX),
    .o_win    (w_win),
    .o_border (w_border)
  );

  // The centre tap carries no weight in either Sobel kernel.
  assign w_unused_center = ^w_win[1][1];

  assign w_gx = (px2g(w_win[0][2]) + (px2g(w_win[1][2]) <<< 1) + px2g(w_win[2][2]))
              - (px2g(w_win[0][0]) + (px2g(w_win[1][0]) <<< 1) + px2g(w_win[2][0]));
  assign w_gy = (px2g(w_win[2][0]) + (px2g(w_win[2][1]) <<< 1) + px2g(w_win[2][2]))
              - (px2g(w_win[0][0]) + (px2g(w_win[0][1]) <<< 1) + px2g(w_win[0][2]));

  assign w_mag = abs_g(r_gx) + abs_g(r_gy);

`ifdef SOBEL_THRESH_EN
  assign w_edge = (w_mag >= GW'(THRESH)) ? PIX_MAX : '0;
`else
  assign w_edge = (w_mag > {{(GW-DW){1'b0}}, PIX_MAX}) ? PIX_MAX : w_mag[DW-1:0];
`endif

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vld_pipe <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_border2  <= 1'b0;
      r_edge     <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], iVAL};
      if (r_vld_pipe[1]) begin
        r_gx      <= w_gx;
        r_gy      <= w_gy;
        r_border2 <= w_border;
      end
      // Output register only moves on valid data so oEDGE holds across gaps.
      if (r_vld_pipe[2]) r_edge <= r_border2 ? '0 : w_edge;
    end
  end

  assign oVAL  = r_vld_pipe[STAGES];
  assign oEDGE = r_edge;

endmodule

// File: tb/tb_sobel_window_filter.sv
// Self-checking bench for sobel_window_filter: directed image patterns plus
// random traffic against a line/column reference model of the Sobel rules.
module tb_sobel_window_filter;

  logic       VGA_CLK = 1'b0;
  logic       RESET_N;
  logic       iVS, iVAL;
  logic [9:0] iTAP_TOP, iTAP_MID, iPIX;
  logic       oVAL;
  logic [9:0] oEDGE;

  sobel_window_filter dut (
    .VGA_CLK (VGA_CLK),
    .RESET_N (RESET_N),
    .iVS     (iVS),
    .iVAL    (iVAL),
    .iTAP_TOP(iTAP_TOP),
    .iTAP_MID(iTAP_MID),
    .iPIX    (iPIX),
    .oVAL    (oVAL),
    .oEDGE   (oEDGE)
  );

  always #5 VGA_CLK = ~VGA_CLK;

`ifdef SOBEL_THRESH_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  typedef struct { int t; int m; int p; } col_t;

  int   total = 0, bad = 0;
  col_t q[$];            // columns of the current line, newest last
  int   col, ln;
  bit   prev_val;
  bit   hv[3];
  int   he[3];
  int   exp_edge;
  int   nval, mx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sobel_ref(input col_t a, input col_t b, input col_t c);
    int gx, gy, mag;
    gx  = (c.t + 2*c.m + c.p) - (a.t + 2*a.m + a.p);
    gy  = (a.p + 2*b.p + c.p) - (a.t + 2*b.t + c.t);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (THR) return (mag >= 128) ? 1023 : 0;
    return (mag > 1023) ? 1023 : mag;
  endfunction

  task automatic model_reset();
    q.delete();
    col = 0; ln = 0; prev_val = 0;
    for (int i = 0; i < 3; i++) begin hv[i] = 0; he[i] = 0; end
    exp_edge = 0;
  endtask

  task automatic step(input bit vs, input bit val, input int t, input int m, input int p);
    int  r_e;
    bit  border;
    @(negedge VGA_CLK);
    iVS = vs; iVAL = val;
    iTAP_TOP = 10'(t); iTAP_MID = 10'(m); iPIX = 10'(p);
    r_e = 0;
    if (val) begin
      q.push_back('{t, m, p});
      if (q.size() > 3) void'(q.pop_front());
      border = !vs || col < 2 || ln < 2;
      if (!border) r_e = sobel_ref(q[0], q[1], q[2]);
    end else if (prev_val) begin
      q.delete();
    end
    if (!vs) begin
      col = 0; ln = 0;
    end else if (val) begin
      if (col < 2) col++;
    end else if (prev_val) begin
      col = 0;
      if (ln < 2) ln++;
    end
    prev_val = val;
    hv[2] = hv[1]; he[2] = he[1];
    hv[1] = hv[0]; he[1] = he[0];
    hv[0] = val;   he[0] = r_e;
    if (hv[2]) exp_edge = he[2];
    @(posedge VGA_CLK);
    #1;
    chk("oVAL", oVAL, hv[2]);
    chk("oEDGE", oEDGE, exp_edge);
    if (oVAL === 1'b1) begin
      nval++;
      if (int'(oEDGE) > mx) mx = int'(oEDGE);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int v;
    RESET_N = 0; iVS = 1; iVAL = 0;
    iTAP_TOP = 0; iTAP_MID = 0; iPIX = 0;
    model_reset();
    nval = 0; mx = 0;
    repeat (2) @(posedge VGA_CLK);
    #1;
    chk("rst_oVAL", oVAL, 0);
    chk("rst_oEDGE", oEDGE, 0);
    @(negedge VGA_CLK);
    RESET_N = 1;

    // Flat field, three lines of 16 px after a frame pulse
    step(0, 0, 0, 0, 0);
    nval = 0; mx = 0;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 16; c++) step(1, 1, 300, 300, 300);
      idle(4);
    end
    chk("flat_count", nval, 48);
    chk("flat_max", mx, 0);

    // Vertical step 0 -> 100
    mx = 0;
    for (int c = 0; c < 16; c++) begin
      v = (c < 8) ? 0 : 100;
      step(1, 1, v, v, v);
    end
    idle(4);
    chk("vstep_max", mx, THR ? 1023 : 400);

    // Saturation with a diagonal across rows
    mx = 0;
    for (int c = 0; c < 10; c++)
      step(1, 1, (c >= 4) ? 1023 : 0, (c >= 5) ? 1023 : 0, (c >= 6) ? 1023 : 0);
    idle(4);
    chk("sat_max", mx, 1023);

    // Valid gaps mid-line: 1,1,0,0,1,1
    nval = 0;
    for (int c = 0; c < 4; c++) step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    for (int c = 0; c < 6; c++) begin
      if (c == 2 || c == 3) step(1, 0, 0, 0, 0);
      else step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    idle(4);
    chk("gap_count", nval, 8);

    // Small step 0 -> 20 (magnitude 80)
    mx = 0;
    for (int c = 0; c < 16; c++) begin
      v = (c < 8) ? 0 : 20;
      step(1, 1, v, v, v);
    end
    idle(4);
    chk("small_step_max", mx, THR ? 0 : 80);

    // Random traffic with occasional frame pulses
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
           $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    idle(4);

    // Frame pulse, then reset in the middle of a line
    step(0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    @(negedge VGA_CLK);
    RESET_N = 0;
    #1;
    chk("midrst_oVAL", oVAL, 0);
    chk("midrst_oEDGE", oEDGE, 0);
    @(negedge VGA_CLK);
    RESET_N = 1; iVAL = 0;
    model_reset();
    mx = 0;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 8; c++) step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      idle(4);
    end
    chk("post_rst_border_max", mx, 0);
    for (int c = 0; c < 8; c++) step(1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
